clkdiv_sched: RTL

Three-channel programmable clock-divider controller. Generates divided clocks CLK_A/CLK_B/CLK_C from CLK_in. Accepts per-channel half-period reconfiguration over a valid/ready port and schedules each change glitch-free at that channel's period boundary. Sits beside the fixed frequency divider as the run-time configurable source for slow clocks and tick enables.

---
 rtl/clkdiv_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/clkdiv_sched.sv
// clkdiv_sched: three-channel run-time programmable clock divider with glitch-free half-period changes.
// Define CLKDIV_SCHED_RDBK_EN to add the rd_ch/rd_half active-half readback port.

// One divider channel: half-period counter, output flop and a pending-change shadow register.
module clkdiv_sched_chan #(
  parameter int CNT_W    = 16,
  parameter int DEF_HALF = 1
) (
  input  logic             CLK_in,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_half,
  output logic             clk_div,
  output logic             tick,
  output logic             busy,
  output logic             pend
`ifdef CLKDIV_SCHED_RDBK_EN
  ,
  output logic [CNT_W-1:0] half_rd
`endif
);

  // state  | meaning
  // S_OFF  | channel disabled, output/counter held 0
  // S_RUN  | dividing with half_q, no change queued
  // S_PEND | dividing with half_q, shadow_q applied at next falling toggle
  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] shadow_q;
  logic             term;

  assign term = (cnt == half_q - CNT_W'(1));
  assign pend = (state == S_PEND);

`ifdef CLKDIV_SCHED_RDBK_EN
  assign half_rd = (state == S_OFF) ? '0 : half_q;
`endif

  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      state    <= S_RUN;
      cnt      <= '0;
      half_q   <= CNT_W'(DEF_HALF);
      shadow_q <= '0;
      clk_div  <= 1'b0;
      tick     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        S_OFF: begin
          cnt     <= '0;
          clk_div <= 1'b0;
          busy    <= 1'b0;
          if (wr_en && (wr_half != '0)) begin
            half_q <= wr_half;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (term) begin
            cnt     <= '0;
            clk_div <= ~clk_div;
            tick    <= ~clk_div;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          // a request landing on a toggle cycle still lets that toggle use the old half
          if (wr_en) begin
            shadow_q <= wr_half;
            busy     <= 1'b1;
            state    <= S_PEND;
          end
        end
        S_PEND: begin
          if (term) begin
            cnt <= '0;
            if (clk_div) begin
              clk_div <= 1'b0;
              half_q  <= shadow_q;
              busy    <= 1'b0;
              state   <= (shadow_q == '0) ? S_OFF : S_RUN;
            end else begin
              clk_div <= 1'b1;
              tick    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= S_OFF;
          cnt     <= '0;
          clk_div <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

module clkdiv_sched #(
  parameter int CNT_W      = 16,
  parameter int DEF_HALF_A = 1,
  parameter int DEF_HALF_B = 5,
  parameter int DEF_HALF_C = 50
) (
  input  logic             CLK_in,
  input  logic             RST,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_err,
  output logic             CLK_A,
  output logic             CLK_B,
  output logic             CLK_C,
  output logic [2:0]       tick,
  output logic [2:0]       busy
`ifdef CLKDIV_SCHED_RDBK_EN
  ,
  input  logic [1:0]       rd_ch,
  output logic [CNT_W-1:0] rd_half
`endif
);

  logic [2:0] clk_v;
  logic [2:0] pend_v;
  logic [2:0] wr_en;
  logic [3:0] pend4;
  logic       xfer;

  // channel 3 never reports pending, so invalid requests are always consumed
  assign pend4     = {1'b0, pend_v};
  assign cfg_ready = ~pend4[cfg_ch];
  assign xfer      = cfg_valid & cfg_ready;

  assign CLK_A = clk_v[0];
  assign CLK_B = clk_v[1];
  assign CLK_C = clk_v[2];

`ifdef CLKDIV_SCHED_RDBK_EN
  logic [CNT_W-1:0] half_v [3];

  always_comb begin
    rd_half = '0;
    case (rd_ch)
      2'd0:    rd_half = half_v[0];
      2'd1:    rd_half = half_v[1];
      2'd2:    rd_half = half_v[2];
      default: rd_half = '0;
    endcase
  end
`endif

  for (genvar g = 0; g < 3; g++) begin : g_ch
    localparam int DEF = (g == 0) ? DEF_HALF_A : ((g == 1) ? DEF_HALF_B : DEF_HALF_C);

    assign wr_en[g] = xfer && (cfg_ch == 2'(g));

    clkdiv_sched_chan #(
      .CNT_W   (CNT_W),
      .DEF_HALF(DEF)
    ) u_ch (
      .CLK_in  (CLK_in),
      .RST     (RST),
      .wr_en   (wr_en[g]),
      .wr_half (cfg_half),
      .clk_div (clk_v[g]),
      .tick    (tick[g]),
      .busy    (busy[g]),
      .pend    (pend_v[g])
`ifdef CLKDIV_SCHED_RDBK_EN
      ,
      .half_rd (half_v[g])
`endif
    );
  end

  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= xfer && (cfg_ch == 2'd3);
    end
  end

endmodule
